// File: rtl/fifo_prog.sv
// fifo_prog
// ---------
// Synchronous single-clock FIFO with programmable almost-full/almost-empty
// watermarks, an occupancy count and sticky overflow/underflow flags.
// The depth may be any integer >= 2. The pointers wrap explicitly rather
// than by power-of-two masking.
// The read port is selectable. FWFT=0 gives a registered standard read.
// FWFT=1 gives first-word-fall-through.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   wr_en, din      write request and write data
//   rd_en, dout     read request and read data
//   af_thresh       almost-full watermark  (almost_full  = count >= af_thresh)
//   ae_thresh       almost-empty watermark (almost_empty = count <= ae_thresh)
//   err_clr         clears the sticky overflow/underflow flags
//   full, empty     occupancy status, registered
//   almost_full,
//   almost_empty    watermark status, registered
//   count           current occupancy
//   overflow        sticky, set when a write was dropped
//   underflow       sticky, set when a read was refused
module fifo_prog #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic [CW-1:0]         af_thresh,
    input  logic [CW-1:0]         ae_thresh,
    input  logic                  err_clr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  rd_acc;
    logic                  wr_acc;
    logic [CW-1:0]         count_next;

    // Pointers wrap from DEPTH-1 back to 0, so any depth works.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // When the FIFO is full, a write is still accepted if a read is accepted
    // in the same cycle. There is no bypass on empty: a write and a read
    // that arrive together on an empty FIFO accept the write only.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    always_comb begin
        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_next = count - 1'b1;
        end
    end

    // Control state. All flags are derived from the count of the next cycle,
    // so they change on the same edge as count. The watermark inputs are
    // sampled every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= (af_thresh == '0);
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == CW'(DEPTH));
            almost_full  <= (count_next >= af_thresh);
            almost_empty <= (count_next <= ae_thresh);

            // If an error and err_clr occur in the same cycle, the error
            // sets the flag.
            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_en && !rd_acc) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    // Storage is not reset. Stale words cannot be reached after a reset
    // because the pointers and count restart at zero.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // The head word is shown directly. dout is forced to 0 while the
            // FIFO is empty so that stale data never appears.
            assign dout = empty ? '0 : mem[rd_ptr];
        end else begin : g_std
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout <= '0;
                end else if (rd_acc) begin
                    dout <= mem[rd_ptr];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fifo_prog.sv
module tb_fifo_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    // DEPTH=16, FWFT=0 instance
    logic       wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic [4:0] af_thresh = 5'd12, ae_thresh = 5'd2;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    // DEPTH=5, FWFT=1 instance
    logic       wr5 = 1'b0, rd5 = 1'b0;
    logic [7:0] din5 = '0;
    logic [7:0] dout5;
    logic [2:0] af5 = 3'd5, ae5 = 3'd0;
    logic       full5, empty5, afull5, aempty5, ovf5, unf5;
    logic [2:0] count5;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    fifo_prog #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) u16 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .err_clr(err_clr), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    fifo_prog #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(1)) u5 (
        .clk(clk), .rst(rst), .wr_en(wr5), .din(din5), .rd_en(rd5),
        .dout(dout5), .af_thresh(af5), .ae_thresh(ae5),
        .err_clr(1'b0), .full(full5), .empty(empty5),
        .almost_full(afull5), .almost_empty(aempty5),
        .count(count5), .overflow(ovf5), .underflow(unf5)
    );

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       rd;
        logic       clr;
        logic [4:0] af;
        logic [4:0] ae;
        int         e_count;
        logic       e_empty;
        logic       e_full;
        logic       e_af;
        logic       e_ae;
        logic       e_ovf;
        logic       e_unf;
        logic [7:0] e_dout;
    } vec_t;

    vec_t vecs [11];

    // Compare one observed value with its expected value and count it
    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive the 16-deep instance for one clock, outputs settle #1 after edge
    task automatic applyStimulus(input logic w, input logic [7:0] d,
                                 input logic r, input logic c);
        wr_en = w; din = d; rd_en = r; err_clr = c;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    endtask

    // Drive the 5-deep FWFT instance for one clock
    task automatic stepFwft(input logic w, input logic [7:0] d, input logic r);
        wr5 = w; din5 = d; rd5 = r;
        @(posedge clk);
        #1;
        wr5 = 1'b0; rd5 = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] e;
        int         c;

        // Vector table: {wr,din,rd,clr,af,ae} -> {count,empty,full,af,ae,ovf,unf,dout}
        vecs[0]  = '{1, 8'hA1, 0, 0, 5'd2, 5'd1, 1, 0, 0, 0, 1, 0, 0, 8'h00};
        vecs[1]  = '{1, 8'hB2, 0, 0, 5'd2, 5'd1, 2, 0, 0, 1, 0, 0, 0, 8'h00};
        vecs[2]  = '{1, 8'hC3, 1, 0, 5'd2, 5'd1, 2, 0, 0, 1, 0, 0, 0, 8'hA1};
        vecs[3]  = '{0, 8'h00, 1, 0, 5'd0, 5'd5, 1, 0, 0, 1, 1, 0, 0, 8'hB2};
        vecs[4]  = '{0, 8'h00, 1, 0, 5'd2, 5'd0, 0, 1, 0, 0, 1, 0, 0, 8'hC3};
        vecs[5]  = '{0, 8'h00, 1, 0, 5'd2, 5'd0, 0, 1, 0, 0, 1, 0, 1, 8'hC3};
        vecs[6]  = '{1, 8'h44, 0, 1, 5'd2, 5'd0, 1, 0, 0, 0, 0, 0, 0, 8'hC3};
        vecs[7]  = '{1, 8'h55, 1, 0, 5'd2, 5'd0, 1, 0, 0, 0, 0, 0, 0, 8'h44};
        vecs[8]  = '{0, 8'h00, 1, 0, 5'd2, 5'd0, 0, 1, 0, 0, 1, 0, 0, 8'h55};
        vecs[9]  = '{1, 8'h66, 1, 0, 5'd2, 5'd0, 1, 0, 0, 0, 0, 0, 1, 8'h55};
        vecs[10] = '{0, 8'h00, 1, 1, 5'd2, 5'd0, 0, 1, 0, 0, 1, 0, 0, 8'h66};

        // Reset state
        doReset();
        checkOutput("rst_count", count, 0);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_aempty", almost_empty, 1);
        checkOutput("rst_afull", almost_full, 0);
        checkOutput("rst_ovf", overflow, 0);
        checkOutput("rst_unf", underflow, 0);
        checkOutput("rst_dout", dout, 0);

        // Table-driven vectors
        for (int i = 0; i < 11; i++) begin
            af_thresh = vecs[i].af;
            ae_thresh = vecs[i].ae;
            applyStimulus(vecs[i].wr, vecs[i].d, vecs[i].rd, vecs[i].clr);
            checkOutput($sformatf("v%0d_count", i), count, vecs[i].e_count);
            checkOutput($sformatf("v%0d_empty", i), empty, vecs[i].e_empty);
            checkOutput($sformatf("v%0d_full", i), full, vecs[i].e_full);
            checkOutput($sformatf("v%0d_afull", i), almost_full, vecs[i].e_af);
            checkOutput($sformatf("v%0d_aempty", i), almost_empty, vecs[i].e_ae);
            checkOutput($sformatf("v%0d_ovf", i), overflow, vecs[i].e_ovf);
            checkOutput($sformatf("v%0d_unf", i), underflow, vecs[i].e_unf);
            checkOutput($sformatf("v%0d_dout", i), dout, vecs[i].e_dout);
        end

        // Alternating write/read pairs with random data
        af_thresh = 5'd12;
        ae_thresh = 5'd2;
        doReset();
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom_range(0, 255));
            sb.push_back(d);
            applyStimulus(1'b1, d, 1'b0, 1'b0);
            checkOutput("alt_count_w", count, 1);
            e = sb.pop_front();
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("alt_dout", dout, e);
            checkOutput("alt_count_r", count, 0);
        end
        checkOutput("alt_ovf", overflow, 0);
        checkOutput("alt_unf", underflow, 0);

        // Fill past full with af_thresh=12, then drain
        for (int i = 1; i <= 20; i++) begin
            d = 8'(8'h30 + i);
            if (i <= 16) sb.push_back(d);
            applyStimulus(1'b1, d, 1'b0, 1'b0);
            c = (i > 16) ? 16 : i;
            checkOutput("fill_count", count, c);
            checkOutput("fill_afull", almost_full, int'(c >= 12));
            checkOutput("fill_full", full, int'(c == 16));
            checkOutput("fill_ovf", overflow, int'(i > 16));
        end
        for (int i = 1; i <= 16; i++) begin
            e = sb.pop_front();
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("drain_dout", dout, e);
            checkOutput("drain_count", count, 16 - i);
            checkOutput("drain_full", full, 0);
        end
        checkOutput("drain_empty", empty, 1);

        // Simultaneous write and read while full
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("clr_ovf", overflow, 0);
        for (int i = 0; i < 16; i++) begin
            d = 8'(8'h80 + i);
            sb.push_back(d);
            applyStimulus(1'b1, d, 1'b0, 1'b0);
        end
        checkOutput("refill_full", full, 1);
        for (int i = 0; i < 8; i++) begin
            d = 8'(8'hC0 + i);
            e = sb.pop_front();
            sb.push_back(d);
            applyStimulus(1'b1, d, 1'b1, 1'b0);
            checkOutput("wr_rd_full_dout", dout, e);
            checkOutput("wr_rd_full_count", count, 16);
            checkOutput("wr_rd_full_full", full, 1);
            checkOutput("wr_rd_full_ovf", overflow, 0);
        end
        for (int i = 0; i < 16; i++) begin
            e = sb.pop_front();
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("order_dout", dout, e);
        end
        checkOutput("order_empty", empty, 1);

        // Reads while empty, then clear
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("unf_set", underflow, 1);
            checkOutput("unf_count", count, 0);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("unf_clear", underflow, 0);

        // Reset during operation with wr_en asserted
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        checkOutput("pre_rst_count", count, 10);
        rst = 1'b1;
        applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0);
        rst = 1'b0;
        checkOutput("mid_rst_count", count, 0);
        checkOutput("mid_rst_empty", empty, 1);
        checkOutput("mid_rst_dout", dout, 0);
        checkOutput("mid_rst_ovf", overflow, 0);
        checkOutput("mid_rst_unf", underflow, 0);
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        checkOutput("post_rst_count", count, 1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("post_rst_dout", dout, 8'h5A);
        checkOutput("post_rst_empty", empty, 1);

        // FWFT, depth 5: three laps of three words
        doReset();
        checkOutput("fwft_rst_dout", dout5, 0);
        checkOutput("fwft_rst_empty", empty5, 1);
        for (int lap = 0; lap < 3; lap++) begin
            d = 8'(8'h20 + lap * 3);
            stepFwft(1'b1, d, 1'b0);
            checkOutput("fwft_first", dout5, d);
            checkOutput("fwft_nempty", empty5, 0);
            stepFwft(1'b1, 8'(d + 1), 1'b0);
            stepFwft(1'b1, 8'(d + 2), 1'b0);
            checkOutput("fwft_hold", dout5, d);
            checkOutput("fwft_count3", count5, 3);
            stepFwft(1'b0, 8'h00, 1'b1);
            checkOutput("fwft_pop1", dout5, d + 1);
            stepFwft(1'b0, 8'h00, 1'b1);
            checkOutput("fwft_pop2", dout5, d + 2);
            stepFwft(1'b0, 8'h00, 1'b1);
            checkOutput("fwft_pop3", dout5, 0);
            checkOutput("fwft_empty", empty5, 1);
        end
        // Fill depth-5 FIFO to full plus one dropped write
        for (int i = 0; i < 6; i++) stepFwft(1'b1, 8'(8'h70 + i), 1'b0);
        checkOutput("fwft_full", full5, 1);
        checkOutput("fwft_count5", count5, 5);
        checkOutput("fwft_ovf", ovf5, 1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("fwft_drain", dout5, 8'h70 + i);
            stepFwft(1'b0, 8'h00, 1'b1);
        end
        checkOutput("fwft_drain_empty", empty5, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_prog.md
# fifo_prog

Parametrised synchronous FIFO with programmable almost-full/almost-empty thresholds, an occupancy count, a selectable first-word-fall-through (FWFT) read mode and sticky overflow/underflow error flags. It replaces the fixed-threshold single-mode `fifo` wherever a producer/consumer pair shares one clock and needs watermark-based flow control. Depth need not be a power of two.

## Interface
- DATA_WIDTH, 8, data word width (≥1)
- DEPTH, 16, number of entries (≥2, any integer)
- FWFT, 0, read mode: 0 = registered standard read, 1 = first-word-fall-through
- CW (localparam), $clog2(DEPTH+1), width of count and threshold ports
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- din  in  DATA_WIDTH  write data
- rd_en  in  1  read request
- dout  out  DATA_WIDTH  read data
- af_thresh  in  CW  almost-full watermark
- ae_thresh  in  CW  almost-empty watermark
- err_clr  in  1  clears sticky error flags
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ af_thresh
- almost_empty  out  1  count ≤ ae_thresh
- count  out  CW  current occupancy
- overflow  out  1  sticky: a write was dropped
- underflow  out  1  sticky: a read was refused

## Operation
- Storage: DEPTH×DATA_WIDTH flop array, not reset. wr_ptr/rd_ptr in 0..DEPTH-1; increment wraps from DEPTH-1 to 0 (no power-of-two masking).
- Read accept: rd_acc = rd_en & !empty.
- Write accept: wr_acc = wr_en & (!full | rd_acc) — full with simultaneous read accepts both, count unchanged.
- Empty with simultaneous rd_en/wr_en: write accepted, read refused (no bypass); underflow set.
- Count next = count + wr_acc − rd_acc; never exceeds DEPTH, never below 0.
- All flags (full, empty, almost_full, almost_empty) are registered, computed from count next, so they agree with count every cycle.
- Thresholds are sampled live each cycle; changing them updates almost_* on the next edge. af_thresh = 0 forces almost_full = 1; ae_thresh ≥ DEPTH forces almost_empty = 1.
- overflow set on wr_en & !wr_acc; underflow set on rd_en & !rd_acc. Both hold until err_clr or rst. err_clr and a new error in the same cycle: set wins.
- FWFT=0: on rd_acc, dout <= mem[rd_ptr]; otherwise dout holds last value.
- FWFT=1: dout = mem[rd_ptr] combinationally while !empty, 0 while empty; rd_acc pops the displayed word.

## Timing
- Reset (rst=1 at an edge): count=0, empty=1, full=0, almost_empty=1 (ae_thresh ≥ 0 always), almost_full = (af_thresh==0), overflow=0, underflow=0, dout=0, pointers=0. Memory contents retained but unreachable.
- Reset mid-operation discards all stored words; next cycle behaves as post-reset regardless of wr_en/rd_en asserted in the reset cycle (ignored, no error flags set).
- Write latency: word written at edge N; empty deasserts and count increments after edge N; in FWFT mode the word appears on dout after edge N.
- Read latency FWFT=0: rd_en at edge N → dout valid after edge N (sampled one cycle later by consumer).
- Read latency FWFT=1: zero; dout valid whenever empty=0, advances after the popping edge.
- Full deasserts the edge after a read from full; empty asserts the edge the last word is read.
- Throughput: one write and one read per cycle sustained, including at full.

## Test plan
- Reset then 20 alternating single write/read pairs of random data, DEPTH=16, FWFT=0 → each dout matches scoreboard one cycle after rd_en; count toggles 0↔1; no error flags.
- Write 20 words with no reads, af_thresh=12 → almost_full rises after the 12th write, full after the 16th, count=16, words 17–20 dropped, overflow=1; then read 16 → data matches first 16 written, empty=1 after 16th read.
- From full, assert wr_en & rd_en together for 8 cycles → count stays 16, full stays 1, overflow not newly set, read order preserved.
- Empty FIFO, rd_en=1 for 3 cycles, then err_clr pulse → underflow=1 from first refused read, count stays 0, underflow=0 after clear.
- FWFT=1, DEPTH=5: write A,B,C → dout=A one cycle after write A with no rd_en; pop three → dout A,B,C then 0 with empty=1; repeat 3 laps to exercise pointer wrap at non-power-of-two depth.
- Write 10 words, assert rst for one cycle with wr_en=1 → count=0, empty=1, dout=0, no error flags; subsequent write/read returns the new word only.
